// File: rtl/bfp16_demux_stream.sv
// ---------------------------------------------------------------------------
// bfp16_demux_stream
//
// Registered 1-to-NUM_OUT demultiplexer for BFP16 operand streams with
// valid/ready flow control. Each accepted beat lands in the one-entry holding
// register of one output lane. The lane is either named by in_sel or taken from
// an internal round-robin pointer. Lanes drain independently, so back-pressure
// on one lane never corrupts or duplicates data on another.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   input beat accepted when in_valid & in_ready (combinational)
//   in_data    input word
//   in_sel     explicit target lane, used when rr_en = 0
//   rr_en      1 = round-robin lane selection, 0 = explicit in_sel
//   out_valid  per-lane holding register full
//   out_ready  per-lane downstream accept
//   out_data   flattened lane words, lane k = [k*DATA_TYPE +: DATA_TYPE]
//   rr_ptr     current round-robin pointer
//   drop_cnt   saturating count of beats discarded for an illegal select
// ---------------------------------------------------------------------------
module bfp16_demux_stream #(
    parameter  int DATA_TYPE = 16,
    parameter  int NUM_OUT   = 4,
    parameter  int CNT_W     = 16,
    localparam int SEL_W     = $clog2(NUM_OUT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_TYPE-1:0]          in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          rr_en,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [NUM_OUT*DATA_TYPE-1:0]  out_data,
    output logic [SEL_W-1:0]              rr_ptr,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_OUT - 1);

    logic [NUM_OUT-1:0]   valid_q, valid_d;
    logic [DATA_TYPE-1:0] data_q [NUM_OUT];
    logic [DATA_TYPE-1:0] data_d [NUM_OUT];
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     drop_q, drop_d;

    logic [SEL_W-1:0]     target;
    logic                 legal;
    logic [NUM_OUT-1:0]   hit;
    logic [NUM_OUT-1:0]   lane_free;
    logic                 accept;

    // Lane decode and ready. A lane can take a beat when it is empty or is
    // being drained this cycle. An illegal select (only reachable in explicit
    // mode with a non power-of-two lane count) is always swallowed.
    always_comb begin
        target    = rr_en ? rr_ptr_q : in_sel;
        legal     = ({1'b0, target} < NUM_OUT_W);
        hit       = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            hit[k] = legal && (target == SEL_W'(k));
        end
        lane_free = ~valid_q | out_ready;
        in_ready  = ~legal | (|(hit & lane_free));
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        // Refill wins over drain so a lane that empties and refills in the same
        // cycle shows no bubble.
        valid_d = (valid_q & ~out_ready) | (hit & {NUM_OUT{accept}});
        for (int k = 0; k < NUM_OUT; k++) begin
            data_d[k] = data_q[k];
            if (accept && hit[k]) begin
                data_d[k] = in_data;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (accept && rr_en) begin
            rr_ptr_d = (rr_ptr_q == LAST_LANE) ? '0 : rr_ptr_q + SEL_W'(1);
        end

        drop_d = drop_q;
        if (accept && !legal && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
            drop_q   <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q;
    assign rr_ptr    = rr_ptr_q;
    assign drop_cnt  = drop_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
        assign out_data[g*DATA_TYPE +: DATA_TYPE] = data_q[g];
    end

endmodule
